// File: rtl/multdiv_sequencer_if.sv
// rtl/multdiv_sequencer_if.sv - start/result handshake between the X-stage sequencer and the multdiv unit
interface multdiv_sequencer_if;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic        md_ready;
    logic        md_exception;
    logic [31:0] md_result;

    modport master (
        output ctrl_mult,
        output ctrl_div,
        input  md_ready,
        input  md_exception,
        input  md_result
    );

    modport slave (
        input  ctrl_mult,
        input  ctrl_div,
        output md_ready,
        output md_exception,
        output md_result
    );
endinterface

// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - X-stage issue/stall/result sequencer for the multi-cycle multiply/divide unit
module multdiv_sequencer #(
    parameter int MAX_CYCLES = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          dx_ir,
    multdiv_sequencer_if.master  md,
    output logic                 stall,
    output logic                 xm_bubble,
    output logic                 result_valid,
    output logic [31:0]          result,
    output logic                 exc_valid,
    output logic [31:0]          exc_code,
    output logic                 timeout
);
    localparam int CW = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [31:0]   result_q;
    logic          op_is_div;
    logic          exc_q;
    logic          timeout_q;

    logic          is_mul;
    logic          is_div;
    logic          is_md;
    logic          issue;
    logic          in_wait;
    logic          in_done;
    logic          unused_ir;

    // Instruction decode: ALU opcode with ALUop selecting multiply or divide
    always_comb begin
        is_mul    = (dx_ir[31:27] == 5'b00000) && (dx_ir[6:2] == 5'b00110);
        is_div    = (dx_ir[31:27] == 5'b00000) && (dx_ir[6:2] == 5'b00111);
        is_md     = is_mul || is_div;
        unused_ir = ^{dx_ir[26:7], dx_ir[1:0]};
        cnt_next  = cnt + CW'(1);
    end

    // Sequencer state, wait counter and captured completion status
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            result_q  <= '0;
            op_is_div <= 1'b0;
            exc_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_md) begin
                        op_is_div <= is_div;
                        cnt       <= '0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt_next;
                    // A ready strobe on the limit cycle is a real completion, not a timeout
                    if (md.md_ready) begin
                        result_q  <= md.md_result;
                        exc_q     <= md.md_exception;
                        timeout_q <= 1'b0;
                        state     <= S_DONE;
                    end else if (cnt_next == CW'(MAX_CYCLES - 1)) begin
                        result_q  <= '0;
                        exc_q     <= 1'b1;
                        timeout_q <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Pipeline-facing outputs; everything is forced low while reset is held
    always_comb begin
        issue        = !reset && (state == S_IDLE) && is_md;
        in_wait      = !reset && (state == S_WAIT);
        in_done      = !reset && (state == S_DONE);
        md.ctrl_mult = issue && is_mul;
        md.ctrl_div  = issue && is_div;
        stall        = issue || in_wait;
        xm_bubble    = issue || in_wait;
        result_valid = in_done;
        result       = in_done ? result_q : 32'd0;
        exc_valid    = in_done && exc_q;
        exc_code     = (in_done && exc_q) ? (op_is_div ? 32'd5 : 32'd4) : 32'd0;
        timeout      = in_done && timeout_q;
    end
endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb/tb_multdiv_sequencer.sv - randomized and directed check of multdiv_sequencer against a behavioural model
module tb_multdiv_sequencer;
    typedef struct packed {
        logic        cm;
        logic        cd;
        logic        st;
        logic        bb;
        logic        rv;
        logic [31:0] res;
        logic        ev;
        logic [31:0] ec;
        logic        to;
    } obs_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] dx_ir = 32'd0;
    logic        md_ready = 1'b0;
    logic        md_exception = 1'b0;
    logic [31:0] md_result = 32'd0;

    logic        st0, bb0, rv0, ev0, to0;
    logic [31:0] res0, ec0;
    logic        st1, bb1, rv1, ev1, to1;
    logic [31:0] res1, ec1;

    multdiv_sequencer_if if0 ();
    multdiv_sequencer_if if1 ();

    assign if0.md_ready     = md_ready;
    assign if0.md_exception = md_exception;
    assign if0.md_result    = md_result;
    assign if1.md_ready     = md_ready;
    assign if1.md_exception = md_exception;
    assign if1.md_result    = md_result;

    multdiv_sequencer #(.MAX_CYCLES(64)) u_dut64 (
        .clock(clock), .reset(reset), .dx_ir(dx_ir), .md(if0),
        .stall(st0), .xm_bubble(bb0), .result_valid(rv0), .result(res0),
        .exc_valid(ev0), .exc_code(ec0), .timeout(to0)
    );

    multdiv_sequencer #(.MAX_CYCLES(8)) u_dut8 (
        .clock(clock), .reset(reset), .dx_ir(dx_ir), .md(if1),
        .stall(st1), .xm_bubble(bb1), .result_valid(rv1), .result(res1),
        .exc_valid(ev1), .exc_code(ec1), .timeout(to1)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    obs_t got [2];

    // Model: one op in flight per instance, described by issue cycle and completion record
    int          max_c [2] = '{64, 8};
    bit          m_busy [2];
    bit          m_done [2];
    int          m_issue [2];
    bit          m_div [2];
    logic [31:0] m_res [2];
    bit          m_exc [2];
    bit          m_to [2];

    function automatic bit ir_mul(logic [31:0] ir);
        return ir[31:27] == 5'd0 && ir[6:2] == 5'b00110;
    endfunction

    function automatic bit ir_div(logic [31:0] ir);
        return ir[31:27] == 5'd0 && ir[6:2] == 5'b00111;
    endfunction

    function automatic obs_t model_out(int i);
        obs_t o;
        o = '0;
        if (reset) return o;
        if (m_done[i]) begin
            o.rv  = 1'b1;
            o.res = m_res[i];
            o.ev  = m_exc[i];
            o.ec  = m_exc[i] ? (m_div[i] ? 32'd5 : 32'd4) : 32'd0;
            o.to  = m_to[i];
        end else if (m_busy[i]) begin
            o.st = 1'b1;
            o.bb = 1'b1;
        end else if (ir_mul(dx_ir) || ir_div(dx_ir)) begin
            o.cm = ir_mul(dx_ir);
            o.cd = ir_div(dx_ir);
            o.st = 1'b1;
            o.bb = 1'b1;
        end
        return o;
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_busy[i] = 0;
                m_done[i] = 0;
            end else if (m_done[i]) begin
                m_done[i] = 0;
            end else if (m_busy[i]) begin
                if (md_ready) begin
                    m_busy[i] = 0; m_done[i] = 1;
                    m_res[i] = md_result; m_exc[i] = md_exception; m_to[i] = 0;
                end else if (cyc - m_issue[i] == max_c[i] - 1) begin
                    m_busy[i] = 0; m_done[i] = 1;
                    m_res[i] = 32'd0; m_exc[i] = 1; m_to[i] = 1;
                end
            end else if (ir_mul(dx_ir) || ir_div(dx_ir)) begin
                m_busy[i] = 1;
                m_issue[i] = cyc;
                m_div[i] = ir_div(dx_ir);
            end
        end
    endtask

    // One clock cycle: compare both instances against the model, then advance
    task automatic step();
        obs_t e;
        @(negedge clock);
        got[0] = '{if0.ctrl_mult, if0.ctrl_div, st0, bb0, rv0, res0, ev0, ec0, to0};
        got[1] = '{if1.ctrl_mult, if1.ctrl_div, st1, bb1, rv1, res1, ev1, ec1, to1};
        for (int i = 0; i < 2; i++) begin
            e = model_out(i);
            total++;
            if (got[i] !== e) begin
                bad++;
                $display("FAIL model_cmp cycle=%0d inst=%0d got=%h exp=%h", cyc, i, got[i], e);
            end
        end
        @(posedge clock);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic lit(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(logic [4:0] aluop);
        logic [31:0] ir;
        ir = $urandom;
        ir[31:27] = 5'd0;
        ir[6:2] = aluop;
        return ir;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        dx_ir = mk(5'b00110);
        md_ready = 1'b0;
        md_exception = 1'b0;
        step();
        lit("reset_outputs0", {31'd0, got[0] != '0}, 32'd0);
        lit("reset_outputs1", {31'd0, got[1] != '0}, 32'd0);
        reset = 1'b0;
        dx_ir = mk(5'b00000);
    endtask

    int pulses;

    initial begin
        do_reset();

        // Non-md traffic
        for (int k = 0; k < 10; k++) begin
            dx_ir = mk(5'b00000);
            step();
            lit("add_quiet", {31'd0, got[0] != '0}, 32'd0);
        end

        // Mul ready after 16 cycles
        do_reset();
        dx_ir = mk(5'b00110);
        step();
        lit("mul_ctrl_t0", {31'd0, got[0].cm}, 32'd1);
        pulses = 0;
        for (int k = 1; k <= 15; k++) begin
            step();
            pulses += got[0].cm;
            lit("mul_stall_wait", {31'd0, got[0].st}, 32'd1);
        end
        md_ready = 1'b1;
        md_result = 32'h0000_0F00;
        step();
        pulses += got[0].cm;
        lit("mul_stall_t16", {31'd0, got[0].st}, 32'd1);
        lit("mul_extra_pulses", pulses, 32'd0);
        md_ready = 1'b0;
        dx_ir = mk(5'b00000);
        step();
        lit("mul_rv", {31'd0, got[0].rv}, 32'd1);
        lit("mul_result", got[0].res, 32'h0000_0F00);
        lit("mul_ev", {31'd0, got[0].ev}, 32'd0);
        lit("mul_stall_done", {31'd0, got[0].st}, 32'd0);

        // Div by zero
        do_reset();
        dx_ir = mk(5'b00111);
        step();
        lit("div_ctrl_t0", {31'd0, got[0].cd}, 32'd1);
        step();
        step();
        md_ready = 1'b1;
        md_exception = 1'b1;
        md_result = $urandom;
        step();
        md_ready = 1'b0;
        md_exception = 1'b0;
        dx_ir = mk(5'b00000);
        step();
        lit("dbz_ev", {31'd0, got[0].ev}, 32'd1);
        lit("dbz_code", got[0].ec, 32'd5);
        lit("dbz_rv", {31'd0, got[0].rv}, 32'd1);
        lit("dbz_to", {31'd0, got[0].to}, 32'd0);

        // Timeout on the MAX_CYCLES=8 instance
        do_reset();
        dx_ir = mk(5'b00110);
        step();
        for (int k = 1; k <= 7; k++) step();
        dx_ir = mk(5'b00000);
        step();
        lit("to_rv", {31'd0, got[1].rv}, 32'd1);
        lit("to_flag", {31'd0, got[1].to}, 32'd1);
        lit("to_code", got[1].ec, 32'd4);
        lit("to_result", got[1].res, 32'd0);

        // Ready on the limit cycle wins over timeout
        do_reset();
        dx_ir = mk(5'b00110);
        step();
        for (int k = 1; k <= 6; k++) step();
        md_ready = 1'b1;
        md_result = 32'h0000_1234;
        step();
        md_ready = 1'b0;
        dx_ir = mk(5'b00000);
        step();
        lit("lim_rv", {31'd0, got[1].rv}, 32'd1);
        lit("lim_to", {31'd0, got[1].to}, 32'd0);
        lit("lim_result", got[1].res, 32'h0000_1234);

        // Back-to-back mul then div
        do_reset();
        dx_ir = mk(5'b00110);
        step();
        lit("b2b_mul_pulse", {31'd0, got[0].cm}, 32'd1);
        step();
        md_ready = 1'b1;
        md_result = $urandom;
        step();
        md_ready = 1'b0;
        dx_ir = mk(5'b00111);
        step();
        lit("b2b_done_no_div", {31'd0, got[0].cd}, 32'd0);
        lit("b2b_done_rv", {31'd0, got[0].rv}, 32'd1);
        step();
        lit("b2b_div_pulse", {31'd0, got[0].cd}, 32'd1);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            pulses += got[0].cd + got[0].cm;
        end
        lit("b2b_single_pulse", pulses, 32'd0);

        // Reset in the middle of a div
        do_reset();
        dx_ir = mk(5'b00111);
        step();
        step();
        reset = 1'b1;
        dx_ir = mk(5'b00000);
        step();
        lit("rst_mid_zero", {31'd0, got[0] != '0}, 32'd0);
        reset = 1'b0;
        step();
        lit("rst_after_zero", {31'd0, got[0] != '0}, 32'd0);
        step();
        md_ready = 1'b1;
        md_result = $urandom;
        step();
        md_ready = 1'b0;
        step();
        lit("rst_late_ready", {31'd0, got[0].rv}, 32'd0);

        // Randomized traffic
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            reset = ($urandom_range(0, 199) == 0);
            case ($urandom_range(0, 3))
                0: dx_ir = mk(5'b00110);
                1: dx_ir = mk(5'b00111);
                2: dx_ir = mk(5'b00000);
                default: dx_ir = $urandom;
            endcase
            md_ready = ($urandom_range(0, 9) == 0);
            md_exception = ($urandom_range(0, 3) == 0);
            md_result = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
